// File: rtl/pipeline_trace_uart_tx.sv
// pipeline_trace_uart_tx
//   Captures the five ARM stage PCs plus the ID-stage instruction on a
//   capture pulse and sends them to a host as a 26-byte 8N1 UART frame:
//   0xA5, if/id/exe/mem/wb PC, id_instruction (each big-endian), then the
//   XOR of bytes 1..24.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   capture            snapshot request, accepted only while not busy
//   if_pc .. wb_pc     stage PCs (32 bits each)
//   id_instruction     instruction in the ID stage
//   tx                 UART serial output, idles high
//   busy               high while a frame is in flight
//   done               one-cycle pulse after the final stop bit
//   overrun            sticky: a capture arrived while busy
module pipeline_trace_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic [31:0] if_pc,
  input  logic [31:0] id_pc,
  input  logic [31:0] exe_pc,
  input  logic [31:0] mem_pc,
  input  logic [31:0] wb_pc,
  input  logic [31:0] id_instruction,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    SYNC      = 8'hA5;
  localparam logic [4:0]    LAST_BYTE = 5'd25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [BW-1:0]  baud_cnt, baud_n;
  logic [2:0]     bit_cnt, bit_n;
  logic [4:0]     byte_idx, idx_n;
  logic [7:0]     cur_byte, cur_n;
  logic [191:0]   snap, snap_n;
  logic [7:0]     csum, csum_n;
  logic           tx_n, busy_n, done_n, ovr_n;
  logic           bit_end;

  // XOR of all 24 payload bytes: fold the six words, then the four bytes.
  function automatic logic [7:0] payload_xor(input logic [31:0] a, b, c, d, e, f);
    logic [31:0] w;
    w = a ^ b ^ c ^ d ^ e ^ f;
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      cur_byte <= '0;
      snap     <= '0;
      csum     <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      byte_idx <= idx_n;
      cur_byte <= cur_n;
      snap     <= snap_n;
      csum     <= csum_n;
      tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
      overrun  <= ovr_n;
    end
  end

  // tx is registered, so each transition loads the level of the *next* bit.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    idx_n   = byte_idx;
    cur_n   = cur_byte;
    snap_n  = snap;
    csum_n  = csum;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;
    ovr_n   = overrun;
    bit_end = (baud_cnt == BAUD_LAST);

    case (state)
      IDLE: begin
        if (capture) begin
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          baud_n  = '0;
          bit_n   = '0;
          idx_n   = '0;
          cur_n   = SYNC;
          snap_n  = {if_pc, id_pc, exe_pc, mem_pc, wb_pc, id_instruction};
          csum_n  = payload_xor(if_pc, id_pc, exe_pc, mem_pc, wb_pc, id_instruction);
        end
      end
      START: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = cur_byte[0];
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_cnt + 3'd1;
            tx_n  = cur_byte[bit_n];
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (byte_idx == LAST_BYTE) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = START;
            tx_n    = 1'b0;
            idx_n   = byte_idx + 5'd1;
            if (idx_n == LAST_BYTE) begin
              cur_n = csum;
            end else begin
              cur_n  = snap[191:184];
              snap_n = {snap[183:0], 8'h00};
            end
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    if (capture && busy) ovr_n = 1'b1;
  end

endmodule

// File: tb/tb_pipeline_trace_uart_tx.sv
// Directed self-checking bench for pipeline_trace_uart_tx at CLKS_PER_BIT=4.
module tb_pipeline_trace_uart_tx;

  localparam int CPB      = 4;
  localparam int FRAME    = 260 * CPB;
  localparam int M_PLAIN  = 0;
  localparam int M_CHANGE = 1;
  localparam int M_OVR    = 2;
  localparam int M_B2B    = 3;

  logic        clk, rst, capture;
  logic [31:0] if_pc, id_pc, exe_pc, mem_pc, wb_pc, id_instruction;
  logic        tx, busy, done, overrun;

  logic        txlog [0:FRAME-1];
  logic [7:0]  exp_b [0:25];
  int          n_assert = 0;
  int          n_fail   = 0;

  pipeline_trace_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk            (clk),
    .rst            (rst),
    .capture        (capture),
    .if_pc          (if_pc),
    .id_pc          (id_pc),
    .exe_pc         (exe_pc),
    .mem_pc         (mem_pc),
    .wb_pc          (wb_pc),
    .id_instruction (id_instruction),
    .tx             (tx),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input logic [31:0] a, b, c, d, e, f);
    if_pc = a; id_pc = b; exe_pc = c; mem_pc = d; wb_pc = e; id_instruction = f;
  endtask

  // Expected frame from hand-supplied words and hand-computed checksum.
  task automatic set_exp(input logic [31:0] a, b, c, d, e, f, input logic [7:0] cs);
    logic [191:0] p;
    p = {a, b, c, d, e, f};
    exp_b[0] = 8'hA5;
    for (int i = 0; i < 24; i++) exp_b[i+1] = p[191-8*i -: 8];
    exp_b[25] = cs;
  endtask

  task automatic pulse_capture();
    capture = 1'b1;
    tick();
    capture = 1'b0;
    chk("start_tx", 32'(tx), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  // Entered in cycle N+1 (first cycle of the start bit of byte 0).
  task automatic rx_frame(input int mode);
    int         busy_low, done_cnt;
    logic [7:0] b;
    busy_low = 0;
    done_cnt = 0;
    for (int c = 0; c < FRAME; c++) begin
      txlog[c] = tx;
      if (busy !== 1'b1) busy_low++;
      if (done !== 1'b0) done_cnt++;
      if (mode == M_CHANGE && c == 0) set_in('1, '1, '1, '1, '1, '1);
      if (mode == M_OVR) capture = (c == 499);
      tick();
    end
    capture = 1'b0;
    chk("busy_whole_frame", 32'(busy_low), 32'd0);
    chk("no_done_in_frame", 32'(done_cnt), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("tx_idle_end", 32'(tx), 32'd1);
    for (int j = 0; j < 26; j++) begin
      chk("start_bit", 32'(txlog[(10*j)*CPB + 2]), 32'd0);
      for (int i = 0; i < 8; i++) b[i] = txlog[(10*j + 1 + i)*CPB + 2];
      chk("frame_byte", {24'(j), b}, {24'(j), exp_b[j]});
      chk("stop_bit", 32'(txlog[(10*j + 9)*CPB + 2]), 32'd1);
    end
    if (mode == M_B2B) begin
      set_in(32'hDEADBEEF, '0, '0, '0, '0, '0);
      capture = 1'b1;
    end
    tick();
    capture = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    capture = 1'b0;
    set_in('0, '0, '0, '0, '0, '0);

    // Reset and idle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      tick();
    end

    // Single frame
    set_in(32'h10, 32'h0C, 32'h08, 32'h04, 32'h00, 32'hE3A01005);
    set_exp(32'h10, 32'h0C, 32'h08, 32'h04, 32'h00, 32'hE3A01005, 8'h46);
    pulse_capture();
    rx_frame(M_PLAIN);
    chk("single_overrun", 32'(overrun), 32'd0);
    repeat (5) tick();

    // Inputs change one cycle after capture
    set_in(32'h10, 32'h0C, 32'h08, 32'h04, 32'h00, 32'hE3A01005);
    pulse_capture();
    rx_frame(M_CHANGE);
    repeat (5) tick();

    // Capture while busy at N+500
    set_in(32'h10, 32'h0C, 32'h08, 32'h04, 32'h00, 32'hE3A01005);
    pulse_capture();
    rx_frame(M_OVR);
    chk("overrun_set", 32'(overrun), 32'd1);
    for (int i = 0; i < 40; i++) begin
      chk("ovr_no_second_busy", 32'(busy), 32'd0);
      chk("ovr_no_second_tx", 32'(tx), 32'd1);
      chk("overrun_sticky", 32'(overrun), 32'd1);
      tick();
    end

    do_reset();
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // Back-to-back: capture in the done cycle
    set_in(32'h10, 32'h0C, 32'h08, 32'h04, 32'h00, 32'hE3A01005);
    pulse_capture();
    rx_frame(M_B2B);
    chk("b2b_start_tx", 32'(tx), 32'd0);
    chk("b2b_start_busy", 32'(busy), 32'd1);
    set_exp(32'hDEADBEEF, '0, '0, '0, '0, '0, 8'h22);
    rx_frame(M_PLAIN);
    chk("b2b_overrun", 32'(overrun), 32'd0);
    repeat (3) tick();

    // Reset and capture in the same cycle: reset wins
    rst = 1'b1;
    capture = 1'b1;
    tick();
    rst = 1'b0;
    capture = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rstcap_busy", 32'(busy), 32'd0);
      chk("rstcap_tx", 32'(tx), 32'd1);
      tick();
    end

    // Reset asserted at N+300
    set_in(32'h10, 32'h0C, 32'h08, 32'h04, 32'h00, 32'hE3A01005);
    pulse_capture();
    repeat (299) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    begin
      int dcnt;
      dcnt = 0;
      for (int i = 0; i < 1100; i++) begin
        if (done !== 1'b0 || busy !== 1'b0) dcnt++;
        tick();
      end
      chk("midrst_quiet", 32'(dcnt), 32'd0);
    end
    set_in(32'h11111111, '0, '0, '0, '0, 32'h000000FF);
    set_exp(32'h11111111, '0, '0, '0, '0, 32'h000000FF, 8'hFF);
    pulse_capture();
    rx_frame(M_PLAIN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
